// File: rtl/led_blinker_core.sv
// LED blinker core: four free-running half-period counters, one per blink
// rate, each flipping its own toggle register. The switches select which
// toggle drives the LED. i_enable acts as both run enable and asynchronous
// active-low reset.

module led_blinker_core #(
    parameter int unsigned c100 = 125000,
    parameter int unsigned c50  = 250000,
    parameter int unsigned c10  = 1250000,
    parameter int unsigned c1   = 12500000
) (
    input  logic i_clock,
    input  logic i_enable,
    input  logic i_switch_1,
    input  logic i_switch_2,
    output logic o_led_drive
);

    // One counter width per rate so that each counter holds 0..cX-1
    localparam int unsigned W100 = $clog2(c100) + 1;
    localparam int unsigned W50  = $clog2(c50) + 1;
    localparam int unsigned W10  = $clog2(c10) + 1;
    localparam int unsigned W1   = $clog2(c1) + 1;

    // Terminal counts at which each counter wraps and flips its toggle
    localparam logic [W100-1:0] LAST100 = W100'(c100 - 1);
    localparam logic [W50-1:0]  LAST50  = W50'(c50 - 1);
    localparam logic [W10-1:0]  LAST10  = W10'(c10 - 1);
    localparam logic [W1-1:0]   LAST1   = W1'(c1 - 1);

    logic [W100-1:0] cnt_100;
    logic [W50-1:0]  cnt_50;
    logic [W10-1:0]  cnt_10;
    logic [W1-1:0]   cnt_1;

    logic tog_100;
    logic tog_50;
    logic tog_10;
    logic tog_1;

    logic selected;

    // 100 Hz half-period counter and toggle
    always_ff @(posedge i_clock or negedge i_enable) begin
        if (!i_enable) begin
            cnt_100 <= '0;
            tog_100 <= 1'b0;
        end else if (cnt_100 == LAST100) begin
            cnt_100 <= '0;
            tog_100 <= ~tog_100;
        end else begin
            cnt_100 <= cnt_100 + W100'(1);
        end
    end

    // 50 Hz half-period counter and toggle
    always_ff @(posedge i_clock or negedge i_enable) begin
        if (!i_enable) begin
            cnt_50 <= '0;
            tog_50 <= 1'b0;
        end else if (cnt_50 == LAST50) begin
            cnt_50 <= '0;
            tog_50 <= ~tog_50;
        end else begin
            cnt_50 <= cnt_50 + W50'(1);
        end
    end

    // 10 Hz half-period counter and toggle
    always_ff @(posedge i_clock or negedge i_enable) begin
        if (!i_enable) begin
            cnt_10 <= '0;
            tog_10 <= 1'b0;
        end else if (cnt_10 == LAST10) begin
            cnt_10 <= '0;
            tog_10 <= ~tog_10;
        end else begin
            cnt_10 <= cnt_10 + W10'(1);
        end
    end

    // 1 Hz half-period counter and toggle
    always_ff @(posedge i_clock or negedge i_enable) begin
        if (!i_enable) begin
            cnt_1 <= '0;
            tog_1 <= 1'b0;
        end else if (cnt_1 == LAST1) begin
            cnt_1 <= '0;
            tog_1 <= ~tog_1;
        end else begin
            cnt_1 <= cnt_1 + W1'(1);
        end
    end

    // Combinational rate select; a switch change shows up with no clock latency
    always_comb begin
        selected = 1'b0;
        case ({i_switch_1, i_switch_2})
            2'b00:   selected = tog_100;
            2'b01:   selected = tog_50;
            2'b10:   selected = tog_10;
            2'b11:   selected = tog_1;
            default: selected = 1'b0;
        endcase
    end

    // Gating with i_enable forces the LED low the instant reset asserts
    assign o_led_drive = i_enable & selected;

endmodule

// File: tb/tb_led_blinker_core.sv
// Bench for led_blinker_core: a table of {select, edges to advance, expected
// LED} records for the main rate sequence, plus hand-written sequences for
// reset hold, mid-run reset and the minimum half-period instance.

module tb_led_blinker_core;

    logic clock;
    logic enable;
    logic switch_1;
    logic switch_2;
    logic led;

    logic enable_min;
    logic switch_min_1;
    logic switch_min_2;
    logic led_min;

    int n_vec;
    int n_err;

    typedef struct {
        logic [1:0] sel;
        int         edges;
        logic       expected;
    } vec_t;

    vec_t vecs[$];

    led_blinker_core #(
        .c100(10),
        .c50 (20),
        .c10 (50),
        .c1  (100)
    ) dut_main (
        .i_clock    (clock),
        .i_enable   (enable),
        .i_switch_1 (switch_1),
        .i_switch_2 (switch_2),
        .o_led_drive(led)
    );

    led_blinker_core #(
        .c100(1),
        .c50 (2),
        .c10 (3),
        .c1  (4)
    ) dut_min (
        .i_clock    (clock),
        .i_enable   (enable_min),
        .i_switch_1 (switch_min_1),
        .i_switch_2 (switch_min_2),
        .o_led_drive(led_min)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic apply_stimulus(input logic [1:0] sel, input int edges);
        {switch_1, switch_2} = sel;
        repeat (edges) @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string name, input logic actual, input logic expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        enable       = 1'b0;
        switch_1     = 1'b0;
        switch_2     = 1'b0;
        enable_min   = 1'b0;
        switch_min_1 = 1'b0;
        switch_min_2 = 1'b0;

        // Main-instance timeline, edges counted from release
        vecs.push_back('{2'b00, 9,   1'b0});
        vecs.push_back('{2'b00, 1,   1'b1});
        vecs.push_back('{2'b00, 9,   1'b1});
        vecs.push_back('{2'b00, 1,   1'b0});
        vecs.push_back('{2'b00, 5,   1'b0});
        vecs.push_back('{2'b01, 0,   1'b1});
        vecs.push_back('{2'b01, 14,  1'b1});
        vecs.push_back('{2'b01, 1,   1'b0});
        vecs.push_back('{2'b01, 20,  1'b1});
        vecs.push_back('{2'b00, 0,   1'b0});
        vecs.push_back('{2'b10, 0,   1'b1});
        vecs.push_back('{2'b10, 39,  1'b1});
        vecs.push_back('{2'b10, 1,   1'b0});
        vecs.push_back('{2'b11, 0,   1'b1});
        vecs.push_back('{2'b11, 99,  1'b1});
        vecs.push_back('{2'b11, 1,   1'b0});
        vecs.push_back('{2'b11, 100, 1'b1});

        // Reset hold with the switches wandering
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(2'(i), 1);
            check_output("reset_hold", led, 1'b0);
        end
        n_vec++;
        if (dut_main.cnt_100 !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_hold_cnt: got %0d, expected 0", dut_main.cnt_100);
        end
        check_output("min_reset_hold", led_min, 1'b0);

        // Release between edges and walk the rate table
        @(negedge clock);
        enable = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].sel, vecs[i].edges);
            check_output($sformatf("vec%0d", i), led, vecs[i].expected);
        end

        // Mid-run reset while the LED is high, away from any clock edge
        #3;
        enable = 1'b0;
        #1;
        check_output("midrun_reset_led", led, 1'b0);
        n_vec++;
        if (dut_main.cnt_1 !== '0) begin
            n_err++;
            $display("[TB] FAIL midrun_reset_cnt: got %0d, expected 0", dut_main.cnt_1);
        end

        // Re-release restarts timing from zero
        @(negedge clock);
        enable = 1'b1;
        apply_stimulus(2'b00, 9);
        check_output("rerelease_e9", led, 1'b0);
        apply_stimulus(2'b00, 1);
        check_output("rerelease_e10", led, 1'b1);
        apply_stimulus(2'b11, 0);
        check_output("rerelease_sel11", led, 1'b0);

        // Minimum half-period: toggles every clock after release
        @(negedge clock);
        enable_min = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock);
            #1;
            check_output($sformatf("min_edge%0d", k), led_min, 1'((k % 2)));
        end
        // At edge 6: c50=2 -> 3 toggles, c10=3 -> 2 toggles, c1=4 -> 1 toggle
        {switch_min_1, switch_min_2} = 2'b01;
        #1;
        check_output("min_sel01", led_min, 1'b1);
        {switch_min_1, switch_min_2} = 2'b10;
        #1;
        check_output("min_sel10", led_min, 1'b0);
        {switch_min_1, switch_min_2} = 2'b11;
        #1;
        check_output("min_sel11", led_min, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
